// File: rtl/mux_scan_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared widths, state encoding and select-stepping helper for
//                the mux scan serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Advance the mux select by one position; the 4-bit wrap is intentional.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel,
                                                  input logic             msb_first);
        return msb_first ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_scan_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_serializer_if
//  Description : Load handshake, mux drive/return and serial stream bundle.
//                master = upstream/environment side, slave = serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_serializer_if;
    import mux_pkg::*;

    logic              load_valid;
    logic              load_ready;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] mux_I;
    logic [SEL_W-1:0]  mux_sel;
    logic              mux_out;
    logic              ser_data;
    logic              ser_valid;
    logic              ser_last;
    logic              busy;

    modport master (
        output load_valid, load_data, mux_out,
        input  load_ready, mux_I, mux_sel, ser_data, ser_valid, ser_last, busy
    );

    modport slave (
        input  load_valid, load_data, mux_out,
        output load_ready, mux_I, mux_sel, ser_data, ser_valid, ser_last, busy
    );

endinterface : mux_scan_serializer_if
`default_nettype wire

// File: rtl/mux16_1.sv
`default_nettype none
// ============================================================================
//  Module      : mux16_1
//  Description : Existing 16:1 combinational bit multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux16_1 (
    input  logic [15:0] I,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = I[sel];

endmodule : mux16_1
`default_nettype wire

// File: rtl/mux_scan_serializer_bit_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bit_tick_gen
//  Description : Mod-BIT_CYCLES counter; tick marks the last cycle of each
//                serial bit period. clear restarts the period.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_tick_gen #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    // A one-cycle period still needs a 1-bit counter to stay a legal vector.
    localparam int              CNT_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BIT_CYCLES - 1);

    if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
        $error("bit_tick_gen: BIT_CYCLES must be >= 1");
    end

    logic [CNT_W-1:0] r_cnt;

    // Period counter: wraps at the last cycle, restarts on clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule : bit_tick_gen
`default_nettype wire

// File: rtl/mux_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_serializer
//  Description : Holds a 16-bit word on an external 16:1 mux, walks its select
//                through all positions and registers the mux output as a
//                framed serial stream (ser_valid / ser_last).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_serializer
    import mux_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_scan_serializer_if.slave bus
);

    localparam logic [SEL_W-1:0] c_SEL_START = MSB_FIRST ? SEL_W'(WORD_W - 1) : '0;
    localparam logic [SEL_W-1:0] c_LAST_BIT  = SEL_W'(WORD_W - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_mux_I;
    logic [SEL_W-1:0]  r_mux_sel;
    logic [SEL_W-1:0]  r_bit_cnt;
    logic              r_ser_data;
    logic              r_ser_valid;
    logic              r_ser_last;

    logic              w_tick;
    logic              w_tick_clear;
    logic              w_sample;
    logic              w_last_bit;
    logic              w_load_ready;
    logic              w_busy;
    logic              w_accept;

    // Period counter is parked at zero while idle and restarted on every accept,
    // so the first sample lands exactly BIT_CYCLES edges after the accept.
    assign w_tick_clear = w_accept || (r_state == IDLE);

    bit_tick_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_tick_clear),
        .tick  (w_tick)
    );

    assign w_sample   = (r_state == SHIFT) && w_tick;
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);
    assign w_accept   = bus.load_valid && w_load_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a word accepted on the final sample edge keeps us in SHIFT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_sample && w_last_bit && !w_accept) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and counters only (independent of load_valid).
    always_comb begin
        w_load_ready = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE:    w_load_ready = 1'b1;
            SHIFT: begin
                w_busy       = 1'b1;
                w_load_ready = w_sample && w_last_bit;
            end
            default: w_load_ready = 1'b0;
        endcase
    end

    // Datapath: capture mux output on sample edges, step select, reload on accept.
    // The accept branch comes last so a reload overrides the select step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mux_I     <= '0;
            r_mux_sel   <= '0;
            r_bit_cnt   <= '0;
            r_ser_data  <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
        end else begin
            r_ser_valid <= w_sample;
            r_ser_last  <= w_sample && w_last_bit;
            if (w_sample) begin
                r_ser_data <= bus.mux_out;
                r_bit_cnt  <= r_bit_cnt + SEL_W'(1);
                r_mux_sel  <= next_sel(r_mux_sel, MSB_FIRST);
            end
            if (w_accept) begin
                r_mux_I   <= bus.load_data;
                r_mux_sel <= c_SEL_START;
                r_bit_cnt <= '0;
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.busy       = w_busy;
    assign bus.mux_I      = r_mux_I;
    assign bus.mux_sel    = r_mux_sel;
    assign bus.ser_data   = r_ser_data;
    assign bus.ser_valid  = r_ser_valid;
    assign bus.ser_last   = r_ser_last;

endmodule : mux_scan_serializer
`default_nettype wire

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Sequencer that drives the team's existing 16:1 mux (mux16_1) to turn a 16-bit word into a serial bit stream.
- Accepts a parallel word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select through all 16 positions, one bit period per position.
- Registers the mux output into a framed serial stream (ser_valid / ser_last).
- Sits around the mux: it feeds the I and sel inputs and consumes out.

Parameters:
- BIT_CYCLES, 1, clock cycles per serial bit; must be >= 1, otherwise elaboration error.
- MSB_FIRST, 0, 0 = index 0 first (sel counts up); 1 = index 15 first (sel counts down).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a word this cycle
- load_data  input  16  parallel word to serialize
- mux_I  output  16  held word, wired to mux I[15:0]
- mux_sel  output  4  current bit index, wired to mux sel[3:0]
- mux_out  input  1  mux out, combinational function of mux_I and mux_sel
- ser_data  output  1  serial bit, valid when ser_valid=1
- ser_valid  output  1  one-cycle pulse per serialized bit
- ser_last  output  1  high with ser_valid on the 16th bit of a word
- busy  output  1  high while state is SHIFT

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; mux_I=0; mux_sel=0; tick counter=0; bit counter=0.
  - ser_data=0; ser_valid=0; ser_last=0; busy=0.
  - An in-flight word is dropped and no further ser_valid is produced.
- States: IDLE and SHIFT.
- load_ready:
  - 1 in IDLE.
  - 1 in SHIFT only during the final cycle of the final bit period (bit counter=15, tick=BIT_CYCLES-1).
  - 0 otherwise.
  - Purely combinational from state and counters; it does not depend on load_valid.
- Accept happens when load_valid && load_ready at an edge:
  - mux_I <= load_data.
  - mux_sel <= (MSB_FIRST ? 15 : 0).
  - tick <= 0; bit counter <= 0; state <= SHIFT.
- SHIFT, each cycle: tick increments.
- SHIFT, when tick = BIT_CYCLES-1 (sample edge):
  - ser_data <= mux_out; ser_valid <= 1 for the next cycle only.
  - ser_last <= (bit counter==15).
  - tick <= 0; bit counter increments.
  - mux_sel steps +1, or -1 when MSB_FIRST=1.
- End of word, at the sample edge with bit counter = 15:
  - If a new word is accepted at the same edge, reload as above and stay in SHIFT. Back-to-back words have no idle bit period.
  - Otherwise state <= IDLE. mux_I and mux_sel hold their last values.
- Wrap-around: mux_sel is 4 bits. The 16th step wraps (15->0 or 0->15) and is harmless in IDLE. The bit counter is 4 bits plus end detection and never exceeds 15.
- Latency for a word accepted at edge E:
  - First ser_valid is high in the cycle after edge E+BIT_CYCLES.
  - Last ser_valid is high in the cycle after edge E+16*BIT_CYCLES.
- load_valid while load_ready=0 is ignored, with no side effects. The upstream holds load_valid and load_data until the handshake.
- mux_I is stable for the whole word, so mux_out is settled one full cycle before each sample edge.
- Reset asserted mid-word takes priority over everything, including a simultaneous accept.

Decomposition:
- Shared package (mux_pkg):
  - WORD_W=16, SEL_W=4.
  - State enum {IDLE, SHIFT}.
  - Function next_sel(sel, msb_first).
- One natural sub-module: bit_tick_gen.
  - Parameter BIT_CYCLES.
  - Ports: clk, rst, clear, tick.
  - Its mod-BIT_CYCLES counter produces the sample strobe.
- The 16:1 mux stays external. The bench instantiates mux16_1 between mux_I/mux_sel and mux_out.

Test Plan:
- Reset, then load 16'hA5C3, BIT_CYCLES=1, MSB_FIRST=0 -> ser_data sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on 16 consecutive ser_valid cycles, ser_last only on the 16th, then busy=0 and load_ready=1.
- MSB_FIRST=1, load 16'h8001 -> mux_sel steps 15,14..0; ser_data 1, fourteen 0s, 1.
- BIT_CYCLES=3, load 16'hFFFF -> ser_valid pulses exactly every 3 cycles; first pulse in the cycle after edge E+3; 16 pulses total.
- Two words 16'h0001 then 16'hFFFE with load_valid held high -> second accepted on the final sample edge of the first; 32 contiguous bits with no gap; ser_last on bits 16 and 32.
- Assert rst for one cycle after 5 bits of 16'h1234 -> all outputs 0 on the next cycle, no further ser_valid, load_ready=1.
- load_valid pulsed while busy (not on the final edge) -> word ignored; mux_I unchanged; output stream identical to the undisturbed case.
